// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one port of a true dual-port BRAM between two requesters. Each cycle
// at most one single-beat read or write is granted, combinationally, using
// round-robin on ties. A requester can hold the port across cycles with its
// lock input. Read data comes back one cycle after the grant and is routed to
// the requester that issued the read.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_req0/1                access request
//   i_we0/1                 1 = write, 0 = read
//   i_lock0/1               keep the grant next cycle while still requesting
//   i_addr0/1, i_din0/1     word address, write data
//   o_gnt0/1                access accepted this cycle (combinational)
//   o_rvalid0/1, o_rdata0/1 read return; o_rdata is 0 while o_rvalid is low
//   addr, en, we, din       BRAM port drive
//   qout                    BRAM read data, valid one cycle after a read
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic                  i_lock0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [DATA_WIDTH-1:0] i_din0,
    output logic                  o_gnt0,
    output logic                  o_rvalid0,
    output logic [DATA_WIDTH-1:0] o_rdata0,

    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic                  i_lock1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_din1,
    output logic                  o_gnt1,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata1,

    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  en,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] qout
);

    // Requesters never issue addresses at or above MEM_SIZE, so the arbiter
    // passes addresses through without range checking.
    localparam int unsigned DEPTH = MEM_SIZE;

    // Registered state
    logic r_last_gnt;    // index granted most recently
    logic r_locked;      // lock active
    logic r_lock_owner;  // index that holds the lock
    logic r_rd_pend;     // a read was granted last cycle
    logic r_rd_id;       // which requester that read belongs to

    // Arbitration result
    logic w_any_gnt;
    logic w_winner;
    logic w_owner_req;
    logic w_win_we;
    logic w_win_lock;

    // The lock only applies while its owner is still requesting; once the
    // owner drops its request the other side competes normally.
    assign w_owner_req = r_lock_owner ? i_req1 : i_req0;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        w_any_gnt = 1'b0;
        w_winner  = 1'b0;
        if (r_locked && w_owner_req) begin
            w_any_gnt = 1'b1;
            w_winner  = r_lock_owner;
        end else if (i_req0 && i_req1) begin
            // Tie: the side not served most recently wins.
            w_any_gnt = 1'b1;
            w_winner  = ~r_last_gnt;
        end else if (i_req0 || i_req1) begin
            w_any_gnt = 1'b1;
            w_winner  = i_req1;
        end
    end

    assign o_gnt0 = w_any_gnt & ~w_winner;
    assign o_gnt1 = w_any_gnt &  w_winner;

    assign w_win_we   = w_winner ? i_we1   : i_we0;
    assign w_win_lock = w_winner ? i_lock1 : i_lock0;

    // BRAM drive: winner's request, all zero when idle.
    always_comb begin
        en   = w_any_gnt;
        addr = '0;
        we   = 1'b0;
        din  = '0;
        if (w_any_gnt) begin
            addr = w_winner ? i_addr1 : i_addr0;
            we   = w_win_we;
            din  = w_winner ? i_din1  : i_din0;
        end
    end

    // Arbitration state. last_gnt resets to 1 so requester 0 wins the first
    // tie after reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt   <= 1'b1;
            r_locked     <= 1'b0;
            r_lock_owner <= 1'b0;
        end else if (w_any_gnt) begin
            r_last_gnt   <= w_winner;
            r_locked     <= w_win_lock;
            r_lock_owner <= w_winner;
        end else begin
            r_locked     <= 1'b0;
        end
    end

    // Read-return tag, aligned with the BRAM's one-cycle registered output.
    // Resetting rd_pend drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_rd_id   <= 1'b0;
        end else begin
            r_rd_pend <= w_any_gnt & ~w_win_we;
            if (w_any_gnt) begin
                r_rd_id <= w_winner;
            end
        end
    end

    assign o_rvalid0 = r_rd_pend & ~r_rd_id;
    assign o_rvalid1 = r_rd_pend &  r_rd_id;
    assign o_rdata0  = o_rvalid0 ? qout : '0;
    assign o_rdata1  = o_rvalid1 ? qout : '0;

endmodule
